// File: rtl/bcd_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | bcd_pkg                                                            |
// | Shared constants, FSM encoding and digit helpers for BCD decoding. |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package bcd_pkg;

    localparam int c_NDIG_DEFAULT = 4;
    localparam logic [3:0] c_DIGIT_MAX = 4'd9;
    localparam logic [3:0] c_NEG_THRESHOLD = 4'd5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CONV = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // A leading digit of 5..9 (or any invalid code) marks a negative
    // ten's-complement operand.
    function automatic logic msd_is_negative(input logic [3:0] msd);
        return (msd >= c_NEG_THRESHOLD);
    endfunction

    function automatic logic digit_is_invalid(input logic [3:0] digit);
        return (digit > c_DIGIT_MAX);
    endfunction

endpackage : bcd_pkg
`default_nettype wire

// File: rtl/bcd_digit_comp.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | bcd_digit_comp                                                     |
// | One-digit ten's-complement step: (9-d)+carry mod 10, or pass-thru. |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module bcd_digit_comp
    import bcd_pkg::*;
(
    input  logic [3:0] digit_i,
    input  logic       carry_i,
    input  logic       negate_i,
    output logic [3:0] digit_o,
    output logic       carry_o,
    output logic       invalid_o
);

    logic [3:0] w_nines;
    logic [3:0] w_sum;
    logic       w_wrap;

    assign w_nines   = c_DIGIT_MAX - digit_i;
    // Only a nines-complement of 9 plus an incoming carry reaches ten.
    assign w_wrap    = (w_nines == c_DIGIT_MAX) && carry_i;
    assign w_sum     = w_nines + {3'b000, carry_i};

    assign digit_o   = !negate_i ? digit_i : (w_wrap ? 4'd0 : w_sum);
    assign carry_o   = negate_i && w_wrap;
    assign invalid_o = digit_is_invalid(digit_i);

endmodule : bcd_digit_comp
`default_nettype wire

// File: rtl/bcd_signmag_decoder.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | bcd_signmag_decoder                                                |
// | Serial ten's-complement BCD to sign/magnitude BCD, one digit/clk.  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module bcd_signmag_decoder #(
    parameter int NDIG = bcd_pkg::c_NDIG_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [4*NDIG-1:0] din,
    output logic              busy,
    output logic              done,
    output logic              sign,
    output logic [4*NDIG-1:0] mag,
    output logic              err
);
    import bcd_pkg::*;

    localparam int c_W     = 4 * NDIG;
    localparam int c_CNT_W = $clog2(NDIG + 1);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(NDIG - 1);

    state_t             state_q, state_d;
    logic [c_W-1:0]     work_q, work_d;
    logic [c_CNT_W-1:0] cnt_q, cnt_d;
    logic               carry_q, carry_d;
    logic               err_acc_q, err_acc_d;
    logic               sign_q, sign_d;
    logic [c_W-1:0]     mag_q, mag_d;
    logic               err_q, err_d;

    logic [3:0]         w_dig_out;
    logic               w_carry_out;
    logic               w_invalid;
    logic [c_W-1:0]     w_shifted;
    logic               w_err_final;

    bcd_digit_comp u_digit_comp (
        .digit_i   (work_q[3:0]),
        .carry_i   (carry_q),
        .negate_i  (sign_q),
        .digit_o   (w_dig_out),
        .carry_o   (w_carry_out),
        .invalid_o (w_invalid)
    );

    // The LSD is consumed from the bottom while its result enters at the
    // top, so after NDIG shifts the register holds the finished magnitude.
    generate
        if (NDIG > 1) begin : g_shift_multi
            assign w_shifted = {w_dig_out, work_q[c_W-1:4]};
        end else begin : g_shift_single
            assign w_shifted = w_dig_out;
        end
    endgenerate

    assign w_err_final = err_acc_q || w_invalid;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            work_q    <= '0;
            cnt_q     <= '0;
            carry_q   <= 1'b0;
            err_acc_q <= 1'b0;
            sign_q    <= 1'b0;
            mag_q     <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            work_q    <= work_d;
            cnt_q     <= cnt_d;
            carry_q   <= carry_d;
            err_acc_q <= err_acc_d;
            sign_q    <= sign_d;
            mag_q     <= mag_d;
            err_q     <= err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        work_d    = work_q;
        cnt_d     = cnt_q;
        carry_d   = carry_q;
        err_acc_d = err_acc_q;
        sign_d    = sign_q;
        mag_d     = mag_q;
        err_d     = err_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d   = ST_CONV;
                    work_d    = din;
                    cnt_d     = '0;
                    carry_d   = 1'b1;
                    err_acc_d = 1'b0;
                    sign_d    = msd_is_negative(din[c_W-1 -: 4]);
                end
            end
            ST_CONV: begin
                work_d    = w_shifted;
                carry_d   = w_carry_out;
                err_acc_d = w_err_final;
                cnt_d     = cnt_q + c_CNT_W'(1);
                if (cnt_q == c_CNT_LAST) begin
                    state_d = ST_DONE;
                    err_d   = w_err_final;
                    mag_d   = w_err_final ? '0 : w_shifted;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign busy = (state_q == ST_CONV);
    assign done = (state_q == ST_DONE);
    assign sign = sign_q;
    assign mag  = mag_q;
    assign err  = err_q;

endmodule : bcd_signmag_decoder
`default_nettype wire

// File: tb/tb_bcd_signmag_decoder.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_bcd_signmag_decoder                                             |
// | Random + directed bench against an arithmetic reference model.     |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_bcd_signmag_decoder;

    localparam int NDIG = 4;
    localparam int W    = 4 * NDIG;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] din = '0;
    logic         busy, done, sign, err;
    logic [W-1:0] mag;

    int n_vec = 0;
    int n_err = 0;
    bit cmp_en = 1'b0;

    // Reference model state: remaining busy cycles, pending result, outputs.
    int           m_left = 0;
    bit           m_done = 1'b0;
    bit           m_sign = 1'b0;
    bit           m_err = 1'b0;
    logic [W-1:0] m_mag = '0;
    bit           p_err = 1'b0;
    logic [W-1:0] p_mag = '0;

    bcd_signmag_decoder #(.NDIG(NDIG)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .din   (din),
        .busy  (busy),
        .done  (done),
        .sign  (sign),
        .mag   (mag),
        .err   (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Decode by value: negative operands are 10^NDIG minus their value.
    function automatic void ref_conv(input logic [W-1:0] d, output bit s,
                                     output logic [W-1:0] m, output bit e);
        int unsigned v = 0;
        int unsigned p = 1;
        logic [3:0]  dig;
        e = 1'b0;
        for (int i = 0; i < NDIG; i++) begin
            dig = d[4*i +: 4];
            if (dig > 4'd9) e = 1'b1;
            v += int'(dig) * p;
            p *= 10;
        end
        s = (d[W-1 -: 4] >= 4'd5);
        if (s) v = p - v;
        m = '0;
        if (!e) begin
            for (int i = 0; i < NDIG; i++) begin
                m[4*i +: 4] = 4'(v % 10);
                v = v / 10;
            end
        end
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_left = 0; m_done = 0; m_sign = 0; m_err = 0; m_mag = '0;
        end else if (m_done) begin
            m_done = 0;
        end else if (m_left > 0) begin
            m_left--;
            if (m_left == 0) begin
                m_done = 1; m_mag = p_mag; m_err = p_err;
            end
        end else if (start) begin
            ref_conv(din, m_sign, p_mag, p_err);
            m_left = NDIG;
        end
    end

    always @(posedge clk) begin
        #2;
        if (cmp_en) begin
            check("busy", busy, m_left > 0);
            check("done", done, m_done);
            check("sign", sign, m_sign);
            check("mag",  mag,  m_mag);
            check("err",  err,  m_err);
        end
    end

    task automatic run_lit(input logic [W-1:0] v, input bit exp_sign,
                           input logic [W-1:0] exp_mag, input bit exp_err,
                           input bit disturb);
        int  busy_cycles = 0;
        bit  got = 0;
        int  guard = 0;
        @(negedge clk);
        while ((busy || done) && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        start = 1'b1;
        din   = v;
        for (int i = 0; i < 20 && !got; i++) begin
            @(posedge clk);
            #1;
            if (i == 0) start = 1'b0;
            if (disturb && i == 1) begin
                start = 1'b1;
                din   = ~v;
            end
            if (disturb && i == 2) start = 1'b0;
            if (done) got = 1;
            else if (busy) busy_cycles++;
        end
        start = 1'b0;
        check("done_seen", got, 1'b1);
        check("busy_len", busy_cycles, NDIG);
        check("lit_sign", sign, exp_sign);
        check("lit_mag",  mag,  exp_mag);
        check("lit_err",  err,  exp_err);
    endtask

    initial begin
        #1000000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        logic [W-1:0] r;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_sign", sign, 1'b0);
        check("rst_mag",  mag,  '0);
        check("rst_err",  err,  1'b0);
        @(negedge clk);
        reset  = 1'b0;
        cmp_en = 1'b1;

        run_lit(16'h0123, 1'b0, 16'h0123, 1'b0, 1'b0);
        run_lit(16'h9877, 1'b1, 16'h0123, 1'b0, 1'b0);
        run_lit(16'h5000, 1'b1, 16'h5000, 1'b0, 1'b0);
        run_lit(16'h4999, 1'b0, 16'h4999, 1'b0, 1'b0);
        run_lit(16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0);
        run_lit(16'h12A4, 1'b0, 16'h0000, 1'b1, 1'b0);
        run_lit(16'h0456, 1'b0, 16'h0456, 1'b0, 1'b1);
        run_lit(16'h9999, 1'b1, 16'h0001, 1'b0, 1'b0);

        // Reset during the second conversion cycle must clear outputs at once.
        @(negedge clk);
        @(negedge clk);
        start = 1'b1;
        din   = 16'h0321;
        @(posedge clk); #1; start = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        #1;
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_done", done, 1'b0);
        check("mid_rst_mag",  mag,  '0);
        check("mid_rst_sign", sign, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        run_lit(16'h9990, 1'b1, 16'h0010, 1'b0, 1'b0);

        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            for (int i = 0; i < NDIG; i++)
                r[4*i +: 4] = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(10, 15))
                                                          : 4'($urandom_range(0, 9));
            din   = r;
            start = ($urandom_range(0, 2) == 0);
            reset = ($urandom_range(0, 99) == 0);
        end
        @(negedge clk);
        start = 1'b0;
        reset = 1'b0;
        repeat (NDIG + 3) @(negedge clk);
        cmp_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_bcd_signmag_decoder
`default_nettype wire

// File: doc/bcd_signmag_decoder.md
BCD_SIGNMAG_DECODER -- requirements
Module: bcd_signmag_decoder

Interface
REQ-001 SHALL have parameter NDIG, default 4: number of BCD digits in the operand.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have port start, input, 1 bit: request to convert din; sampled only in IDLE.
REQ-005 SHALL have port din, input, 4*NDIG bits: ten's-complement BCD operand; digit 0 at bits [3:0], MSD at the top.
REQ-006 SHALL have port busy, output, 1 bit: high while a conversion is in progress.
REQ-007 SHALL have port done, output, 1 bit: single-cycle pulse when results are valid.
REQ-008 SHALL have port sign, output, 1 bit: 1 means the decoded value is negative.
REQ-009 SHALL have port mag, output, 4*NDIG bits: BCD magnitude of the decoded value.
REQ-010 SHALL have port err, output, 1 bit: high when din contained a digit greater than 9.

Function
REQ-011 SHALL implement FSM states IDLE, CONV and DONE.
REQ-012 SHALL, in IDLE with start=1 at a rising edge, capture din into an internal working register and enter CONV.
REQ-013 SHALL, at that same capture edge, set sign to 1 when the MSD of din is 5 or greater and to 0 otherwise, and clear the internal carry to 1.
REQ-014 SHALL process exactly one digit per rising edge in CONV, LSD first, taking NDIG edges regardless of sign.
REQ-015 SHALL, when sign=1, replace each digit d with (9-d)+carry in modulo-10 form, with carry-out = 1 only when 9-d=9 and carry-in=1.
REQ-016 SHALL, when sign=0, pass each digit through unchanged.
REQ-017 SHALL discard the carry out of the MSD.
REQ-018 SHALL set err if any processed digit exceeds 9; err forces mag to all zeros at completion.
REQ-019 SHALL enter DONE on the NDIG-th edge after the capture edge, loading mag and err at that edge; done=1 for exactly that one cycle; return to IDLE on the next edge.
REQ-020 SHALL hold busy=1 in CONV only, and busy=0 in IDLE and DONE.
REQ-021 SHALL ignore start in CONV and DONE; no queuing of requests.
REQ-022 SHALL hold sign, mag and err stable from DONE until the next accepted start.
REQ-023 SHALL treat the value 5 followed by zeros (e.g. 5000 for NDIG=4) as the most negative value: sign=1, mag=5000.

Reset
REQ-024 SHALL, on reset assertion at any time including mid-CONV, immediately force state=IDLE, busy=0, done=0, sign=0, mag=0, err=0, and clear the working register and carry.
REQ-025 SHALL begin accepting start on the first rising edge after reset deasserts.

Structure
REQ-026 SHALL take the state encoding constants and the NDIG default from the shared bcd_pkg package.
REQ-027 SHALL instantiate one combinational sub-module, bcd_digit_comp, which maps (digit, carry_in, negate) to (digit_out, carry_out, invalid); the top level holds the FSM, working shift register, counter and output registers.
REQ-028 SHALL size the digit counter to ceil(log2(NDIG+1)) bits.

Verification (NDIG=4)
REQ-029 SHALL cover: din=0123, start -> at the 4th edge after capture, done=1, sign=0, mag=0123, err=0; busy high for exactly 4 cycles.
REQ-030 SHALL cover: din=9877 -> sign=1, mag=0123; and din=9999 -> sign=1, mag=0001.
REQ-031 SHALL cover the boundaries: din=5000 -> sign=1, mag=5000; din=4999 -> sign=0, mag=4999; din=0000 -> sign=0, mag=0000.
REQ-032 SHALL cover an invalid digit: din=12A4 (0x12A4) -> done=1, err=1, mag=0000.
REQ-033 SHALL cover start pulsed during CONV with din changed -> ignored; result still corresponds to the first captured operand.
REQ-034 SHALL cover reset asserted in the 2nd CONV cycle -> busy, done and mag read 0 immediately; then a new start with din=9990 -> sign=1, mag=0010.
